aoi222_exhaustive_tester: RTL
=============================

Name: aoi222_exhaustive_tester

Overview:
- Stimulus-and-check companion for the aoi222 cell: drives the cell's six inputs, samples ZN and checks it against the cell function.
- On START, walks all 64 input vectors, holds each for a programmable settle time, samples ZN and compares it to ~((A1&A2)|(B1&B2)|(C1&C2)).
- Reports pass/fail, error count and first failing vector.
- Used in library bring-up benches and as an on-silicon cell-characterization BIST wrapper.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before ZN is sampled; legal range 1..255.
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch; 0 = run all 64 vectors.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous active-high reset
- START  input  1  one-cycle run request
- ZN  input  1  cell output under test
- A1  output  1  cell input, vector bit 0
- A2  output  1  cell input, vector bit 1
- B1  output  1  cell input, vector bit 2
- B2  output  1  cell input, vector bit 3
- C1  output  1  cell input, vector bit 4
- C2  output  1  cell input, vector bit 5
- BUSY  output  1  run in progress
- DONE  output  1  run complete; sticky until next START or RST
- PASS  output  1  valid while DONE; 1 = zero mismatches
- ERR_COUNT  output  7  mismatch count, 0..64
- FAIL_VALID  output  1  at least one mismatch recorded
- FAIL_VEC  output  6  vector index of the first mismatch

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RST).
- Reset values: all outputs 0. Reset state is IDLE, vector counter 0, settle counter 0.
- RST asserted mid-run returns the block to IDLE with all outputs 0 on the next edge. No partial results are retained.
- Vector index vec[5:0] = {C2,C1,B2,B1,A2,A1}. The outputs are driven combinationally from the vec register, so they change on the edge that updates vec.
- State machine:
  - IDLE: START=1 -> vec=0, settle=0, ERR_COUNT=0, FAIL_VALID=0, FAIL_VEC=0, DONE=0, PASS=0, BUSY=1, go to HOLD.
  - HOLD: settle increments each cycle. On the cycle where settle==SETTLE_CYCLES-1, ZN is sampled at the following edge.
  - Compare: expected = ~((A1&A2)|(B1&B2)|(C1&C2)). ZN equal to X or Z counts as a mismatch (case-inequality).
  - Mismatch: ERR_COUNT+1. If FAIL_VALID==0, load FAIL_VEC=vec and set FAIL_VALID=1 on the same edge.
  - After the compare: if vec==63, or (STOP_ON_FAIL and a mismatch occurred) -> go to DONE_ST. Otherwise vec+1, settle=0, stay in HOLD.
  - DONE_ST: BUSY=0, DONE=1, PASS=(ERR_COUNT==0 including the final compare). The outputs hold the last vector. START=1 -> same action as in IDLE (restart).
- Latency:
  - BUSY rises on the edge after START is sampled.
  - A full run lasts 64*SETTLE_CYCLES cycles from BUSY rise to DONE rise.
  - With STOP_ON_FAIL at vector v, the run lasts (v+1)*SETTLE_CYCLES cycles.
- START while BUSY is ignored; it has no effect on the count or state.
- vec never wraps. Terminal detection is on 63; the increment past 63 never occurs.
- ERR_COUNT cannot exceed 64, so no saturation logic is needed.
- The PASS and DONE update on the final compare happens on the same edge as the last ERR_COUNT update.

Test Plan:
- Correct aoi222 model on ZN, SETTLE=2, START pulse -> DONE rises 128 cycles after BUSY; PASS=1, ERR_COUNT=0, FAIL_VALID=0. A1..C2 step through 0..63 every 2 cycles.
- ZN tied 1 -> ERR_COUNT=37 (vectors with expected 0), FAIL_VEC=3, FAIL_VALID=1, PASS=0.
- ZN tied 0 -> ERR_COUNT=27, FAIL_VEC=0, PASS=0.
- STOP_ON_FAIL=1, SETTLE=2, ZN tied 1 -> DONE after 8 cycles of BUSY; ERR_COUNT=1, FAIL_VEC=3, outputs hold vec 3.
- RST pulsed at cycle 40 of a run -> all outputs 0 next edge. A new START then gives a clean full run with PASS=1. START pulses during BUSY change nothing.
- ZN driven X for vec 17 only (otherwise correct), SETTLE=1 -> run lasts 64 cycles; ERR_COUNT=1, FAIL_VEC=17, PASS=0.

Source files
------------

// File: rtl/aoi222_exhaustive_tester.sv
// Exhaustive stimulus/check wrapper for an aoi222 cell: walks all 64 input
// vectors, samples ZN after a settle window and tallies mismatches.
module aoi222_exhaustive_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       B1,
  output logic       B2,
  output logic       C1,
  output logic       C2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [6:0] ERR_COUNT,
  output logic       FAIL_VALID,
  output logic [5:0] FAIL_VEC
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DONE_ST
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] vec_q, vec_d;
  logic [7:0] settle_q, settle_d;
  logic [6:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [5:0] fail_vec_q, fail_vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       expected;
  logic       mismatch;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // Case-inequality so that an X or Z on ZN is flagged as a mismatch.
  always_comb begin
    expected = ~((vec_q[0] & vec_q[1]) | (vec_q[2] & vec_q[3]) | (vec_q[4] & vec_q[5]));
    mismatch = (ZN !== expected);
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;

    case (state_q)
      IDLE, DONE_ST: begin
        if (START) begin
          state_d      = HOLD;
          vec_d        = '0;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      HOLD: begin
        if (settle_q == SETTLE_LAST) begin
          if (mismatch) begin
            err_d = err_q + 7'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end
          // Terminal vector is 63; the counter is never advanced past it.
          if ((vec_q == 6'd63) || (STOP_ON_FAIL && mismatch)) begin
            state_d = DONE_ST;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 7'd0);
          end else begin
            vec_d    = vec_q + 6'd1;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {C2, C1, B2, B1, A2, A1} = vec_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_COUNT  = err_q;
  assign FAIL_VALID = fail_valid_q;
  assign FAIL_VEC   = fail_vec_q;

endmodule
